debug_frame_streamer: RTL
=========================

// Module: debug_frame_streamer
// PURPOSE
//  Reader end of the RISCV core's DebugData port. On Trigger it snapshots the packed register file and PC, then streams
//  them as an 11-word, 16-bit frame over a valid/ready interface. The frame goes to a host link or a trace FIFO.
//  The bench and the FPGA top use it instead of probing uut internals.
// PARAMETERS
//  NumRegs     8        architectural registers carried in DebugData
//  RegWidth    16       bits per register, PC and output word
//  HeaderWord  16'hD5B6 frame start marker, first word of every frame
// PORTS
//  Clk        in   1                  system clock, all state on posedge
//  Reset      in   1                  synchronous, active-high
//  DebugData  in   NumRegs*RegWidth   {reg7..reg0}, reg0 in bits [15:0]
//  PC         in   RegWidth           core program counter
//  Trigger    in   1                  request a snapshot; sampled every cycle
//  OutData    out  RegWidth           current frame word
//  OutValid   out  1                  OutData is valid
//  OutReady   in   1                  sink accepts; transfer = OutValid & OutReady
//  OutLast    out  1                  high with the checksum word
//  Busy       out  1                  frame in progress (state != IDLE)
//  DropCount  out  8                  triggers ignored while Busy; saturates at 255
// BEHAVIOUR
//  - Reset (sync, wins over every other input): state=IDLE, OutData=0, OutValid=0, OutLast=0, Busy=0, DropCount=0.
//    Snapshot and checksum registers are cleared. Reset mid-frame aborts the frame; the frame never resumes.
//  - Frame order: HeaderWord, PC, reg0..reg7, Checksum. That is 11 words.
//  - Checksum = two's complement of the mod-2^16 sum of PC and reg0..reg7. The sum of words 2..11 is therefore 0 mod 2^16.
//  - Capture: in IDLE, if Trigger is high at edge N, the snapshot and PC are registered at edge N.
//    The checksum is accumulated during streaming. OutValid=1 with HeaderWord from edge N. Latency is 1 cycle.
//  - FSM states: IDLE -> HDR -> PCW -> REGS (index 0..NumRegs-1) -> CSUM -> IDLE.
//    The state advances only on a transfer. Each state advances one step per transfer.
//  - Handshake: while OutValid=1 and OutReady=0, OutData, OutValid and OutLast hold stable.
//    Snapshot changes on DebugData or PC mid-frame do not affect the frame. OutValid never drops until the transfer.
//  - OutReady held high gives 11 consecutive transfer cycles. There are no bubbles inside a frame.
//  - Trigger while Busy: ignored, and DropCount increments (saturates at 8'hFF). Exception below.
//  - Trigger on the same cycle as the CSUM transfer: the trigger is accepted, not dropped. A new snapshot is taken
//    at that edge and the next cycle presents HeaderWord. This gives back-to-back frames with no idle cycle.
//  - Trigger in IDLE is never counted as a drop. Trigger held high continuously produces continuous frames.
//  - Widths: checksum accumulator is RegWidth bits and wraps. The register index counter is $clog2(NumRegs) bits,
//    with a terminal compare at NumRegs-1.
// STRUCTURE
//  - Shared include riscv_debug_defs.vh holds: state encodings (IDLE, HDR, PCW, REGS, CSUM), the HeaderWord
//    default, FRAME_WORDS=NumRegs+3, and the DebugData slice macro REG_SLICE(i).
//  - One sub-module, debug_word_select: combinational mux from (state, index, snapshot, PC, csum) to OutData.
//    OutData is registered in the parent.
//  - The parent holds the FSM, snapshot registers, checksum accumulator and DropCount.
// TESTING
//  1. Reset, then Trigger pulse with PC=3, regs=0..7, OutReady=1 -> words D5B6,0003,0000..0007,FFE1.
//     OutLast is high only on FFE1. Busy drops the cycle after.
//  2. Same frame with OutReady toggled 1,0,0,1,... -> identical word sequence. OutData is stable during every
//     stall. No word is duplicated or skipped.
//  3. Trigger again at frame words 3 and 7, with the DebugData input changed mid-frame -> DropCount=2.
//     The frame still carries the original snapshot.
//  4. Trigger high through the CSUM transfer with all regs=16'hFFFF, PC=16'hFFFF -> checksum 0009.
//     Header follows on the next cycle. DropCount is unchanged.
//  5. Assert Reset at word 5 with OutReady=0 -> next cycle OutValid=0, Busy=0, DropCount=0.
//     A new Trigger starts a fresh frame at HeaderWord.
//  6. Force 300 busy-time triggers -> DropCount saturates at FF and does not wrap.

Source files
------------

// File: rtl/debug_frame_streamer_pkg.sv
// Shared types and constants for the debug frame streamer: FSM state encoding,
// default frame header and frame length helper.
package debug_frame_streamer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_PCW  = 3'd2,
        ST_REGS = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    localparam logic [15:0] HEADER_WORD_DEFAULT = 16'hD5B6;
    localparam int          DROP_W              = 8;

    // Header + PC + registers + checksum.
    function automatic int frame_words(input int num_regs);
        return num_regs + 3;
    endfunction

endpackage

// File: rtl/debug_frame_streamer_word_select.sv
// Combinational frame-word mux: picks the word that belongs to a given
// (state, register index) from the snapshot, PC and checksum.
module debug_frame_streamer_word_select
    import debug_frame_streamer_pkg::*;
#(
    parameter int                  NumRegs    = 8,
    parameter int                  RegWidth   = 16,
    parameter int                  IdxW       = 3,
    parameter logic [RegWidth-1:0] HeaderWord = RegWidth'(HEADER_WORD_DEFAULT)
) (
    input  state_t                        state,
    input  logic [IdxW-1:0]               idx,
    input  logic [NumRegs*RegWidth-1:0]   snap,
    input  logic [RegWidth-1:0]           pc,
    input  logic [RegWidth-1:0]           csum,
    output logic [RegWidth-1:0]           word
);

    always_comb begin
        word = '0;
        case (state)
            ST_HDR:  word = HeaderWord;
            ST_PCW:  word = pc;
            ST_REGS: word = snap[int'(idx) * RegWidth +: RegWidth];
            ST_CSUM: word = csum;
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/debug_frame_streamer.sv
// Snapshots the core register file and PC on Trigger and streams them as a
// header/PC/regs/checksum frame over a valid/ready port.
module debug_frame_streamer
    import debug_frame_streamer_pkg::*;
#(
    parameter int                  NumRegs    = 8,
    parameter int                  RegWidth   = 16,
    parameter logic [RegWidth-1:0] HeaderWord = RegWidth'(HEADER_WORD_DEFAULT)
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [NumRegs*RegWidth-1:0]   DebugData,
    input  logic [RegWidth-1:0]           PC,
    input  logic                          Trigger,
    output logic [RegWidth-1:0]           OutData,
    output logic                          OutValid,
    input  logic                          OutReady,
    output logic                          OutLast,
    output logic                          Busy,
    output logic [DROP_W-1:0]             DropCount
);

    localparam int              IdxW    = (NumRegs > 1) ? $clog2(NumRegs) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumRegs - 1);

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
    endfunction

    state_t                        state, state_nxt;
    logic [IdxW-1:0]               idx, idx_nxt;
    logic                          xfer, capture, drop, load;

    logic [NumRegs*RegWidth-1:0]   snap_data_p0;
    logic [RegWidth-1:0]           snap_pc_p0;
    logic [RegWidth-1:0]           sum_p0, sum_nxt, csum_nxt, cur_reg;
    logic [RegWidth-1:0]           word_nxt, word_p1;
    logic                          vld_p1, last_p1;
    logic [DROP_W-1:0]             drop_cnt;

    always_comb begin
        xfer      = vld_p1 & OutReady;
        state_nxt = state;
        idx_nxt   = idx;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Trigger) begin
                    capture   = 1'b1;
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (xfer) state_nxt = ST_PCW;
            end
            ST_PCW: begin
                if (xfer) begin
                    state_nxt = ST_REGS;
                    idx_nxt   = '0;
                end
            end
            ST_REGS: begin
                if (xfer) begin
                    if (idx == LastIdx) state_nxt = ST_CSUM;
                    else                idx_nxt   = idx + IdxW'(1);
                end
            end
            ST_CSUM: begin
                // A trigger landing on the checksum transfer chains the next frame
                if (xfer) begin
                    if (Trigger) begin
                        capture   = 1'b1;
                        state_nxt = ST_HDR;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        drop = Trigger & (state != ST_IDLE) & ~capture;
        load = capture | xfer;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Checksum folds in each word as it is transferred, so the value handed to
    // the mux on the last register transfer already includes that register.
    always_comb begin
        cur_reg = snap_data_p0[int'(idx) * RegWidth +: RegWidth];
        sum_nxt = sum_p0;
        if (xfer && (state == ST_PCW))  sum_nxt = sum_p0 + snap_pc_p0;
        if (xfer && (state == ST_REGS)) sum_nxt = sum_p0 + cur_reg;
        csum_nxt = -sum_nxt;
    end

    debug_frame_streamer_word_select #(
        .NumRegs    (NumRegs),
        .RegWidth   (RegWidth),
        .IdxW       (IdxW),
        .HeaderWord (HeaderWord)
    ) u_word_select (
        .state (state_nxt),
        .idx   (idx_nxt),
        .snap  (snap_data_p0),
        .pc    (snap_pc_p0),
        .csum  (csum_nxt),
        .word  (word_nxt)
    );

    // ---- p0: snapshot capture and checksum accumulation ----
    always_ff @(posedge Clk) begin
        if (Reset) begin
            snap_data_p0 <= '0;
            snap_pc_p0   <= '0;
            sum_p0       <= '0;
        end else if (capture) begin
            snap_data_p0 <= DebugData;
            snap_pc_p0   <= PC;
            sum_p0       <= '0;
        end else begin
            sum_p0       <= sum_nxt;
        end
    end

    // ---- p1: registered output word, held while the sink stalls ----
    always_ff @(posedge Clk) begin
        if (Reset) begin
            word_p1  <= '0;
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (load) begin
                word_p1 <= word_nxt;
                vld_p1  <= (state_nxt != ST_IDLE);
                last_p1 <= (state_nxt == ST_CSUM);
            end
            if (drop) drop_cnt <= sat_inc(drop_cnt);
        end
    end

    assign OutData   = word_p1;
    assign OutValid  = vld_p1;
    assign OutLast   = last_p1;
    assign Busy      = (state != ST_IDLE);
    assign DropCount = drop_cnt;

endmodule
